// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, FSM states, datapath select encodings and control vector of the multicycle CPU controller
package cpu_ctrl_pkg;
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_IMM    = 2'b11;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_OUT    = 2'b01;
  localparam logic [1:0] PCS_JMP    = 2'b10;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR,
    EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
  endfunction
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: maps FSM state (plus latched opcode) to the datapath control vector
module multicycle_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       go,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH:   begin ctrl.mem_read = 1'b1; ctrl.ir_write = go; ctrl.pc_write = go; ctrl.alu_src_b = SRCB_4; ctrl.alu_op = ALU_ADD; ctrl.pc_source = PCS_ALU; end
      DECODE:  begin ctrl.alu_src_b = SRCB_SHIMM; ctrl.alu_op = ALU_ADD; end
      MEM_ADR: begin ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = SRCB_IMM; ctrl.alu_op = ALU_ADD; end
      MEM_RD:  begin ctrl.mem_read = 1'b1; ctrl.iord = 1'b1; end
      MEM_WB:  begin ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; end
      MEM_WR:  begin ctrl.mem_write = 1'b1; ctrl.iord = 1'b1; end
      EXEC_R:  begin ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = SRCB_B; ctrl.alu_op = ALU_FUNCT; end
      R_WB:    begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; end
      EXEC_I:  begin ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = SRCB_IMM; ctrl.alu_op = (op == OP_ADDIU) ? ALU_ADD : ALU_IMM; end
      I_WB:    ctrl.reg_write = 1'b1;
      BRANCH:  begin ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = SRCB_B; ctrl.alu_op = ALU_SUB; ctrl.pc_source = PCS_OUT; ctrl.pc_write_cond = (op == OP_BEQ); ctrl.pc_write_cond_ne = (op == OP_BNE); end
      JUMP:    begin ctrl.pc_write = 1'b1; ctrl.pc_source = PCS_JMP; end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM with retired-instruction counter; define MULTICYCLE_MEM_WAIT_EN to stall memory states on mem_ready
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_code,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_write_cond_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);
  state_t     state, state_n;
  logic [5:0] op_q;
  logic       go;
  ctrl_t      dec, ctrl;
`ifdef MULTICYCLE_MEM_WAIT_EN
  assign go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign go = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = go ? DECODE : FETCH;
      DECODE:  state_n = op_code inside {OP_LW, OP_SW} ? MEM_ADR :
                         op_code == OP_R ? EXEC_R :
                         op_code inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI} ? EXEC_I :
                         op_code inside {OP_BEQ, OP_BNE} ? BRANCH :
                         op_code == OP_J ? JUMP : FETCH;
      MEM_ADR: state_n = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  state_n = go ? MEM_WB : MEM_RD;
      MEM_WR:  state_n = go ? FETCH : MEM_WR;
      EXEC_R:  state_n = R_WB;
      EXEC_I:  state_n = I_WB;
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      illegal_op <= 1'b0;
      retired    <= '0;
    end else begin
      if (state == DECODE) op_q <= op_code;
      illegal_op <= (state == DECODE) && !is_legal(op_code);
      if (state_n == FETCH && state != FETCH && state != DECODE) retired <= retired + CNT_W'(1);
    end
  end
  multicycle_ctrl_decode u_decode (
    .state (state),
    .op    (op_q),
    .go    (go),
    .ctrl  (dec)
  );
  assign ctrl = rst ? '0 : dec;
  assign {pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write, ir_write,
          reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source} = ctrl;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level reference model check of multicycle_ctrl, with and without MULTICYCLE_MEM_WAIT_EN
module tb_multicycle_ctrl;
  localparam int CW = 4;
`ifdef MULTICYCLE_MEM_WAIT_EN
  localparam bit WE = 1'b1;
`else
  localparam bit WE = 1'b0;
`endif
  localparam logic [5:0] OPC_R = 6'b000000, OPC_J = 6'b000010, OPC_BEQ = 6'b000100, OPC_BNE = 6'b000101;
  localparam logic [5:0] OPC_ADDIU = 6'b001001, OPC_SLTI = 6'b001010, OPC_ANDI = 6'b001100, OPC_ORI = 6'b001101;
  localparam logic [5:0] OPC_LW = 6'b100011, OPC_SW = 6'b101011;
  localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MW = 4, ST_MS = 5;
  localparam int ST_ER = 6, ST_RW = 7, ST_EI = 8, ST_IW = 9, ST_BR = 10, ST_J = 11;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
  logic [5:0] op_code = '0;
  logic pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write, ir_write;
  logic reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [CW-1:0] retired;
  logic [16:0] obs;
  int checks = 0, passed = 0, fails = 0;
  logic [CW-1:0] ret_m = '0;
  bit ill_m = 1'b0;
  string names [12] = '{"FETCH", "DECODE", "MEM_ADR", "MEM_RD", "MEM_WB", "MEM_WR",
                        "EXEC_R", "R_WB", "EXEC_I", "I_WB", "BRANCH", "JUMP"};
  logic [5:0] ops [10] = '{OPC_LW, OPC_SW, OPC_R, OPC_ADDIU, OPC_ANDI, OPC_ORI, OPC_SLTI, OPC_BEQ, OPC_BNE, OPC_J};

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_cond_ne(pc_write_cond_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .retired(retired)
  );

  assign obs = {pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [16:0] exp_vec(input int s, input logic [5:0] op, input logic rdy);
    logic pcw, cnd, cne, ird, mrd, mwr, irw, rdst, m2r, rw, asa, g;
    logic [1:0] asb, aop, pcs;
    {pcw, cnd, cne, ird, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
    {asb, aop, pcs} = '0;
    g = !WE || rdy;
    case (s)
      ST_F:  begin mrd = 1'b1; irw = g; pcw = g; asb = 2'b01; end
      ST_D:  asb = 2'b11;
      ST_MA: begin asa = 1'b1; asb = 2'b10; end
      ST_MR: begin mrd = 1'b1; ird = 1'b1; end
      ST_MW: begin rw = 1'b1; m2r = 1'b1; end
      ST_MS: begin mwr = 1'b1; ird = 1'b1; end
      ST_ER: begin asa = 1'b1; aop = 2'b10; end
      ST_RW: begin rw = 1'b1; rdst = 1'b1; end
      ST_EI: begin asa = 1'b1; asb = 2'b10; aop = (op == OPC_ADDIU) ? 2'b00 : 2'b11; end
      ST_IW: rw = 1'b1;
      ST_BR: begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; cnd = (op == OPC_BEQ); cne = (op == OPC_BNE); end
      ST_J:  begin pcw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, cnd, cne, ird, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs};
  endfunction

  function automatic int lat(input logic [5:0] op);
    case (op)
      OPC_LW: return 5;
      OPC_SW, OPC_R, OPC_ADDIU, OPC_ANDI, OPC_ORI, OPC_SLTI: return 4;
      OPC_BEQ, OPC_BNE, OPC_J: return 3;
      default: return 2;
    endcase
  endfunction

  // entered and left at posedge+1; memory steps in mask see mem_ready low for their first lows cycles
  task automatic run_instr(input logic [5:0] op, input int lows, input logic [11:0] mask);
    int seq[$];
    int cyc, nmask;
    cyc = 0;
    nmask = 0;
    seq.push_back(ST_F);
    seq.push_back(ST_D);
    case (op)
      OPC_LW: begin seq.push_back(ST_MA); seq.push_back(ST_MR); seq.push_back(ST_MW); end
      OPC_SW: begin seq.push_back(ST_MA); seq.push_back(ST_MS); end
      OPC_R: begin seq.push_back(ST_ER); seq.push_back(ST_RW); end
      OPC_ADDIU, OPC_ANDI, OPC_ORI, OPC_SLTI: begin seq.push_back(ST_EI); seq.push_back(ST_IW); end
      OPC_BEQ, OPC_BNE: seq.push_back(ST_BR);
      OPC_J: seq.push_back(ST_J);
      default: ;
    endcase
    foreach (seq[k]) begin
      int s, stay;
      bit adv, mem;
      s = seq[k];
      stay = 0;
      mem = (s == ST_F || s == ST_MR || s == ST_MS);
      if (mem && mask[s]) nmask++;
      do begin
        mem_ready = (mem && mask[s]) ? (stay >= lows) : (mem ? 1'b1 : 1'($urandom_range(0, 1)));
        op_code = (s == ST_D) ? op : 6'($urandom);
        @(negedge clk);
        chk({names[s], "_ctrl"}, 32'(obs), 32'(exp_vec(s, op, mem_ready)));
        chk("retired", 32'(retired), 32'(ret_m));
        chk("illegal_op", 32'(illegal_op), 32'(k == 0 && stay == 0 && ill_m));
        adv = !(WE && mem && !mem_ready);
        cyc++;
        stay++;
        @(posedge clk);
        #1;
      end while (!adv);
    end
    chk("latency", 32'(cyc), 32'(lat(op) + (WE ? lows * nmask : 0)));
    ill_m = (seq.size() == 2);
    if (!ill_m) ret_m = ret_m + 1'b1;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_ctrl", 32'(obs), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (ops[i]) run_instr(ops[i], 0, '1);
    run_instr(6'b111111, 0, '1);
    run_instr(OPC_J, 0, '1);
    run_instr(OPC_SW, 4, 12'(1 << ST_MS));
    run_instr(OPC_LW, 2, '1);
    // reset held three cycles in the middle of an R-type instruction
    op_code = OPC_R;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    op_code = 6'($urandom);
    @(negedge clk);
    chk("pre_rst_EXEC_R", 32'(obs), 32'(exp_vec(ST_ER, OPC_R, 1'b1)));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 2) begin
        @(negedge clk);
        chk("mid_rst_ctrl", 32'(obs), 32'd0);
        chk("mid_rst_retired", 32'(retired), 32'd0);
      end
    end
    rst = 1'b0;
    ret_m = '0;
    ill_m = 1'b0;
    run_instr(OPC_R, 0, '1);
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      run_instr(op, $urandom_range(0, 2), '1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ret_m = '0;
    ill_m = 1'b0;
    for (int n = 0; n < 16; n++) run_instr(OPC_J, 0, '1);
    @(negedge clk);
    chk("retired_wrap", 32'(retired), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
